imem_fetch_bridge: RTL

IMEM_FETCH_BRIDGE -- requirements
Module: imem_fetch_bridge

---
 rtl/imem_fetch_bridge.sv | 132 +++++++++++++
 1 files changed

// File: rtl/imem_fetch_bridge.sv
// Instruction-fetch bridge: a one-entry line buffer in front of a request/grant/rvalid
// instruction bus. Hits return in the same cycle; misses stall the core until the fill lands.
module imem_fetch_bridge #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] fetch_addr_i,
  output logic [31:0] inst_o,
  output logic        halt_o,
  output logic        bus_req_o,
  output logic [31:0] bus_addr_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_err_i,
  output logic        err_o
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, ERR} state_t;

  state_t          state_q, state_d;
  logic            buf_valid;
  logic [29:0]     buf_tag;
  logic [31:0]     buf_data;
  logic [29:0]     req_word;
  logic [CW-1:0]   cnt_q;

  logic            aligned, hit;
  logic            fill, latch_req, cnt_clr, cnt_inc;

  assign aligned = (fetch_addr_i[1:0] == 2'b00);
  assign hit     = buf_valid && (buf_tag == fetch_addr_i[31:2]) && aligned && (state_q != ERR);

  assign halt_o     = !hit;
  assign inst_o     = hit ? buf_data : NOP_INST;
  assign err_o      = (state_q == ERR);
  assign bus_req_o  = (state_q == REQ);
  // Address is only presented while requesting, so the bus sees zero when idle.
  assign bus_addr_o = bus_req_o ? {req_word, 2'b00} : 32'h0;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    fill      = 1'b0;
    latch_req = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!hit) begin
          if (aligned) begin
            latch_req = 1'b1;
            state_d   = REQ;
          end else begin
            state_d = ERR;
          end
        end
      end
      REQ: begin
        if (bus_gnt_i) begin
          if (bus_rvalid_i) begin
            // Zero-wait response completes the transfer straight from REQ.
            if (bus_err_i) begin
              state_d = ERR;
            end else begin
              fill    = 1'b1;
              state_d = IDLE;
            end
          end else begin
            cnt_clr = 1'b1;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus_rvalid_i) begin
          if (bus_err_i) begin
            state_d = ERR;
          end else begin
            fill    = 1'b1;
            state_d = IDLE;
          end
        end else if (cnt_q >= CW'(TIMEOUT - 1)) begin
          state_d = ERR;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ERR: state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: the buffer payload is reset as well, so inst_o and bus_addr_o are never X after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid <= 1'b0;
      buf_tag   <= '0;
      buf_data  <= '0;
      req_word  <= '0;
      cnt_q     <= '0;
    end else begin
      if (latch_req) begin
        req_word <= fetch_addr_i[31:2];
      end
      if (fill) begin
        buf_valid <= 1'b1;
        buf_tag   <= req_word;
        buf_data  <= bus_rdata_i;
      end
      if (cnt_clr) begin
        cnt_q <= '0;
      end else if (cnt_inc) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule
